ifu: RTL and testbench

Parametrised instruction-fetch unit replacing the single-register PC path of the single-cycle core. Holds the fetch PC, issues sequential requests to instruction memory under credit control, buffers in-order responses in a DEPTH-entry FIFO tagged with their PC, and hands them to the decoder over a valid/ready interface. A redirect from execute (jump or jalr) flushes the buffer, discards stale in-flight responses and restarts fetch at the new target.

---
 rtl/ifu.sv | 119 +++++++++++
 tb/tb_ifu.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction-fetch unit: owns the fetch PC, issues credit-limited sequential
// requests to instruction memory, buffers in-order responses together with
// their PC in a small FIFO and presents them to decode over valid/ready.
// A redirect flushes the buffer, arranges for stale in-flight responses to be
// dropped and restarts fetch at the (possibly jalr-masked) target.
module ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic [1:0]      redirect_mode,
    input  logic [XLEN-1:0] redirect_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            err_q;
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] fifo_inst [DEPTH];

    logic            redirect;
    logic [XLEN-1:0] eff_target;
    logic            misaligned;
    logic [CW:0]     used;
    logic            req_fire;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            pop;

    // Redirect decode: jalr clears bit 0, anything left in bits 1:0 is misaligned
    assign redirect   = redirect_mode[1];
    assign eff_target = {redirect_target[XLEN-1:1], redirect_target[0] & ~redirect_mode[0]};
    assign misaligned = eff_target[1] | eff_target[0];

    // Credit: outstanding requests plus buffered entries may never exceed DEPTH,
    // so every response always has a FIFO slot waiting for it
    assign used           = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid = rst && !err_q && !redirect && (used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop   = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep   = imem_rsp_valid && (drop_cnt == '0);

    assign inst_valid = (count != '0);
    assign inst_data  = fifo_inst[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];
    assign pop        = inst_valid && inst_ready;
    assign fetch_err  = err_q;

    // Control state: PCs, credit counters, FIFO pointers and the sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err_q    <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= eff_target;
            rsp_pc   <= eff_target;
            err_q    <= misaligned;
            inflight <= inflight - CW'(imem_rsp_valid);
            drop_cnt <= inflight - CW'(imem_rsp_valid);
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

    // FIFO payload storage; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (rsp_keep && !redirect) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_inst[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a latency-configurable in-order memory model,
// a scoreboard of expected {pc, inst} pairs popped on every decode handshake,
// a table of redirect/alignment vectors and hand-written multi-cycle sequences.
module tb_ifu;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [1:0]  redirect_mode = 2'b00;
    logic [31:0] redirect_target = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_err;

    ifu #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_mode(redirect_mode), .redirect_target(redirect_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic        exp_err;
        logic        exp_valid;
    } vec_t;

    int          vec_count = 0;
    int          miss_count = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          pop_count = 0;
    int          mem_lat = 1;
    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    int          pop_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h3C5A_96F0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] target);
        redirect_mode   = mode;
        redirect_target = target;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        applyStimulus(2'b00, 32'h0);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        exp_q.delete();
        pop_cyc.delete();
        tick();
        tick();
        hs_count  = 0;
        pop_count = 0;
        rst = 1'b1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput({name, "_outstanding"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Memory: sample handshake mid-cycle, answer in order after mem_lat cycles
    initial begin : mem_model
        bit          hs;
        logic [31:0] hs_addr;
        pend_t       p;
        forever begin
            @(negedge clk);
            hs      = imem_req_valid && imem_req_ready;
            hs_addr = imem_req_addr;
            @(posedge clk);
            cyc++;
            if (hs && rst) begin
                p.addr = hs_addr;
                p.due  = cyc + mem_lat - 1;
                pend_q.push_back(p);
                hs_count++;
            end
            #1;
            if (!rst) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Scoreboard: every decode handshake must match the next expected PC
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && inst_valid && inst_ready) begin
                pop_count++;
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vec_count++;
                    miss_count++;
                    $display("[TB] FAIL unexpected_pop: got pc 0x%08h, expected no instruction", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("inst_pc", inst_pc, e);
                    checkOutput("inst_data", inst_data, mem_word(e));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t vt[9];
        int   n;
        int   base;

        vt[0] = '{2'b11, 32'h8000_0205, 32'h8000_0204, 1'b0, 1'b1};
        vt[1] = '{2'b10, 32'h8000_0202, 32'h8000_0202, 1'b1, 1'b0};
        vt[2] = '{2'b10, 32'h8000_0300, 32'h8000_0300, 1'b0, 1'b1};
        vt[3] = '{2'b11, 32'h8000_0003, 32'h8000_0002, 1'b1, 1'b0};
        vt[4] = '{2'b11, 32'h8000_0401, 32'h8000_0400, 1'b0, 1'b1};
        vt[5] = '{2'b10, 32'h8000_0001, 32'h8000_0001, 1'b1, 1'b0};
        vt[6] = '{2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b1};
        vt[7] = '{2'b01, 32'h1234_5678, 32'hFFFF_FFFC, 1'b0, 1'b1};
        vt[8] = '{2'b00, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0, 1'b1};

        // Reset values while rst is held low
        @(negedge clk);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_fetch_err", fetch_err, 0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);

        // Streaming with 1-cycle memory: one instruction per cycle
        tick();
        rst = 1'b1;
        mem_lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        checkOutput("t1_req_valid", imem_req_valid, 1);
        checkOutput("t1_req_addr", imem_req_addr, RESET_PC);
        for (int i = 0; i < 6; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        tick();
        wait_empty("t1", 30);
        inst_ready = 1'b0;
        checkOutput("t1_pops", pop_cyc.size(), 6);
        for (int i = 1; i < pop_cyc.size(); i++) checkOutput("t1_gap", pop_cyc[i] - pop_cyc[i-1], 1);

        // Backpressure: exactly DEPTH requests, then drain in order
        do_reset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        checkOutput("t2_hs_count", hs_count, DEPTH);
        checkOutput("t2_req_valid_full", imem_req_valid, 0);
        checkOutput("t2_inst_valid_full", inst_valid, 1);
        tick();
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        wait_empty("t2", 20);
        @(negedge clk);
        checkOutput("t2_inst_valid_drained", inst_valid, 0);
        checkOutput("t2_req_valid_drained", imem_req_valid, 1);
        checkOutput("t2_req_addr_drained", imem_req_addr, 32'h8000_0010);

        // 3-cycle memory, redirect with two requests outstanding
        tick();
        do_reset();
        mem_lat = 3;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        n = 0;
        while (hs_count < 2 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t3_hs_count", hs_count, 2);
        imem_req_ready = 1'b0;
        applyStimulus(2'b10, 32'h8000_0100);
        @(negedge clk);
        checkOutput("t3_req_valid_redirect", imem_req_valid, 0);
        tick();
        applyStimulus(2'b00, 32'h0);
        imem_req_ready = 1'b1;
        exp_q.push_back(32'h8000_0100);
        exp_q.push_back(32'h8000_0104);
        exp_q.push_back(32'h8000_0108);
        @(negedge clk);
        checkOutput("t3_inst_valid_after", inst_valid, 0);
        checkOutput("t3_req_valid_after", imem_req_valid, 1);
        checkOutput("t3_req_addr_after", imem_req_addr, 32'h8000_0100);
        tick();
        wait_empty("t3", 40);
        inst_ready = 1'b0;

        // Redirect table: alignment handling and no-redirect modes
        do_reset();
        mem_lat = 1;
        inst_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vt[i].mode, vt[i].target);
            tick();
            applyStimulus(2'b00, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_addr", i), imem_req_addr, vt[i].exp_addr);
            checkOutput($sformatf("vec%0d_err", i), fetch_err, vt[i].exp_err);
            checkOutput($sformatf("vec%0d_req_valid", i), imem_req_valid, vt[i].exp_valid);
            tick();
        end

        // PC wrap from the top of the address space
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        exp_q.push_back(32'h0000_0008);
        imem_req_ready = 1'b1;
        wait_empty("wrap", 30);
        inst_ready = 1'b0;

        // Misaligned redirect stops fetch until an aligned redirect
        do_reset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        repeat (3) tick();
        applyStimulus(2'b10, 32'h8000_0202);
        tick();
        applyStimulus(2'b00, 32'h0);
        base = hs_count;
        repeat (6) tick();
        @(negedge clk);
        checkOutput("t5_err_set", fetch_err, 1);
        checkOutput("t5_no_requests", hs_count, base);
        checkOutput("t5_req_valid", imem_req_valid, 0);
        checkOutput("t5_inst_valid", inst_valid, 0);
        tick();
        applyStimulus(2'b10, 32'h8000_0300);
        tick();
        applyStimulus(2'b00, 32'h0);
        inst_ready = 1'b1;
        exp_q.push_back(32'h8000_0300);
        exp_q.push_back(32'h8000_0304);
        exp_q.push_back(32'h8000_0308);
        @(negedge clk);
        checkOutput("t5_err_cleared", fetch_err, 0);
        tick();
        wait_empty("t5", 30);
        inst_ready = 1'b0;

        // Redirect coinciding with a response and a pop
        do_reset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        n = 0;
        while (pop_count < 2 && n < 20) begin
            tick();
            n++;
        end
        applyStimulus(2'b10, 32'h8000_0500);
        @(negedge clk);
        checkOutput("t6_rsp_coincides", imem_rsp_valid, 1);
        checkOutput("t6_pop_coincides", inst_valid, 1);
        checkOutput("t6_req_valid_redirect", imem_req_valid, 0);
        tick();
        exp_q.delete();
        applyStimulus(2'b00, 32'h0);
        exp_q.push_back(32'h8000_0500);
        exp_q.push_back(32'h8000_0504);
        @(negedge clk);
        checkOutput("t6_fifo_empty", inst_valid, 0);
        checkOutput("t6_pop_count", pop_count, 3);
        tick();
        wait_empty("t6", 30);
        inst_ready = 1'b0;

        // Asynchronous reset in the middle of a burst, then restart
        do_reset();
        mem_lat = 2;
        imem_req_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        checkOutput("t7_pre_inst_valid", inst_valid, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t7_async_inst_valid", inst_valid, 0);
        checkOutput("t7_async_req_valid", imem_req_valid, 0);
        checkOutput("t7_async_req_addr", imem_req_addr, RESET_PC);
        tick();
        tick();
        hs_count = 0;
        rst = 1'b1;
        inst_ready = 1'b1;
        exp_q.push_back(RESET_PC);
        exp_q.push_back(RESET_PC + 32'd4);
        exp_q.push_back(RESET_PC + 32'd8);
        @(negedge clk);
        checkOutput("t7_restart_req_valid", imem_req_valid, 1);
        checkOutput("t7_restart_req_addr", imem_req_addr, RESET_PC);
        tick();
        wait_empty("t7", 30);
        inst_ready = 1'b0;
        applyStimulus(2'b10, 32'h8000_0002);
        tick();
        applyStimulus(2'b00, 32'h0);
        @(negedge clk);
        checkOutput("t7_err_before_reset", fetch_err, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t7_async_err", fetch_err, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
